// File: rtl/plru_array.sv
// plru_array: per-set tree pseudo-LRU replacement state.
// Each set holds WAYS-1 node bits; touch points the path away from the
// accessed way, read registers a victim (lowest invalid way first, else
// the tree walk).
// Optional feature: define PLRU_BYPASS_EN to make a same-set read/touch
// in one cycle see the touched tree (write-first); otherwise read-first.
module plru_array #(
  parameter int S_INDEX  = 3,
  parameter int WAY_BITS = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     read,
  input  logic [S_INDEX-1:0]       rindex,
  input  logic [(2**WAY_BITS)-1:0] valid_mask,
  input  logic                     touch,
  input  logic [S_INDEX-1:0]       windex,
  input  logic [WAY_BITS-1:0]      tway,
  output logic [WAY_BITS-1:0]      victim,
  output logic                     victim_vld,
  output logic                     victim_inv
);

  localparam int SETS  = 2**S_INDEX;
  localparam int WAYS  = 2**WAY_BITS;
  localparam int NODES = WAYS - 1;

  typedef logic [NODES-1:0] row_t;

  row_t tree [SETS];

  // Node n's children are 2n+1 (left) and 2n+2 (right); the way number is
  // consumed MSB first, one bit per level.
  function automatic row_t touch_row(input row_t t, input logic [WAY_BITS-1:0] way);
    row_t                r;
    logic [WAY_BITS-1:0] n;
    logic [WAY_BITS-1:0] w;
    logic                b;
    r = t;
    n = '0;
    w = way;
    for (int l = 0; l < WAY_BITS; l++) begin
      b    = w[WAY_BITS-1];
      r[n] = ~b;
      n    = WAY_BITS'({n, 1'b1}) + WAY_BITS'(b);
      w    = w << 1;
    end
    return r;
  endfunction

  function automatic logic [WAY_BITS-1:0] walk(input row_t t);
    logic [WAY_BITS-1:0] n;
    logic [WAY_BITS-1:0] v;
    logic                b;
    n = '0;
    v = '0;
    for (int l = 0; l < WAY_BITS; l++) begin
      b = t[n];
      v = WAY_BITS'({v, b});
      n = WAY_BITS'({n, 1'b1}) + WAY_BITS'(b);
    end
    return v;
  endfunction

  row_t                row_upd;
  row_t                row_rd;
  logic                any_inv;
  logic [WAY_BITS-1:0] inv_way;

  // Updated row for the touched set; also the forwarding source.
  always_comb begin
    row_upd = touch_row(tree[windex], tway);
  end

  // Row seen by the lookup: stored row, or the just-touched one when forwarding.
  always_comb begin
    row_rd = tree[rindex];
`ifdef PLRU_BYPASS_EN
    if (touch && (windex == rindex)) row_rd = row_upd;
`endif
  end

  // Lowest-index invalid way wins over the tree.
  always_comb begin
    logic [WAYS-1:0] m;
    logic            found;
    m       = valid_mask;
    found   = 1'b0;
    inv_way = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (!m[0] && !found) begin
        inv_way = WAY_BITS'(i);
        found   = 1'b1;
      end
      m = m >> 1;
    end
    any_inv = found;
  end

  // Tree state and registered lookup result; reset drops read and touch.
  always_ff @(posedge clk) begin
    if (rst) begin
      tree       <= '{default: '0};
      victim     <= '0;
      victim_inv <= 1'b0;
      victim_vld <= 1'b0;
    end else begin
      if (touch) tree[windex] <= row_upd;
      victim_vld <= read;
      if (read) begin
        victim     <= any_inv ? inv_way : walk(row_rd);
        victim_inv <= any_inv;
      end
    end
  end

endmodule

// File: tb/tb_plru_array.sv
// tb_plru_array: directed checks on a WAY_BITS=2 instance plus a random
// stream on WAY_BITS 1..4 against a recency-based reference model.
module tb_plru_array;

`ifdef PLRU_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_run  = 0;
  int n_fail = 0;

  logic rd1, tc1, inv1, vv1; logic [2:0] ri1, wi1; logic [1:0]  vm1; logic [0:0] tw1, vic1;
  logic rd2, tc2, inv2, vv2; logic [2:0] ri2, wi2; logic [3:0]  vm2; logic [1:0] tw2, vic2;
  logic rd3, tc3, inv3, vv3; logic [2:0] ri3, wi3; logic [7:0]  vm3; logic [2:0] tw3, vic3;
  logic rd4, tc4, inv4, vv4; logic [2:0] ri4, wi4; logic [15:0] vm4; logic [3:0] tw4, vic4;

  plru_array #(.S_INDEX(3), .WAY_BITS(1)) u1 (.clk(clk), .rst(rst), .read(rd1), .rindex(ri1),
    .valid_mask(vm1), .touch(tc1), .windex(wi1), .tway(tw1), .victim(vic1), .victim_vld(vv1), .victim_inv(inv1));
  plru_array #(.S_INDEX(3), .WAY_BITS(2)) u2 (.clk(clk), .rst(rst), .read(rd2), .rindex(ri2),
    .valid_mask(vm2), .touch(tc2), .windex(wi2), .tway(tw2), .victim(vic2), .victim_vld(vv2), .victim_inv(inv2));
  plru_array #(.S_INDEX(3), .WAY_BITS(3)) u3 (.clk(clk), .rst(rst), .read(rd3), .rindex(ri3),
    .valid_mask(vm3), .touch(tc3), .windex(wi3), .tway(tw3), .victim(vic3), .victim_vld(vv3), .victim_inv(inv3));
  plru_array #(.S_INDEX(3), .WAY_BITS(4)) u4 (.clk(clk), .rst(rst), .read(rd4), .rindex(ri4),
    .valid_mask(vm4), .touch(tc4), .windex(wi4), .tway(tw4), .victim(vic4), .victim_vld(vv4), .victim_inv(inv4));

  // Reference: per way, the time of its last touch (0 = never since reset).
  // A node points away from whichever half holds the most recent touch;
  // with neither half touched it points left.
  longint unsigned ts [4][8][16];
  longint unsigned stamp;

  function automatic void mreset();
    for (int k = 0; k < 4; k++)
      for (int s = 0; s < 8; s++)
        for (int w = 0; w < 16; w++) ts[k][s][w] = 0;
  endfunction

  function automatic void mtouch(input int k, input int s, input int w);
    stamp = stamp + 1;
    ts[k][s][w] = stamp;
  endfunction

  function automatic int mtree(input int k, input int s);
    int lo, size, half;
    longint unsigned ml, mr;
    lo = 0;
    size = 2 << k;
    while (size > 1) begin
      half = size / 2;
      ml = 0;
      mr = 0;
      for (int i = 0; i < half; i++) begin
        if (ts[k][s][lo+i] > ml) ml = ts[k][s][lo+i];
        if (ts[k][s][lo+half+i] > mr) mr = ts[k][s][lo+half+i];
      end
      if (ml > mr) lo = lo + half;
      size = half;
    end
    return lo;
  endfunction

  function automatic void mlook(input int k, input int s, input logic [15:0] vm,
                                output int v, output bit inv);
    v = -1;
    for (int i = 0; i < (2 << k); i++)
      if (v < 0 && ((vm >> i) & 16'h1) == 16'h0) v = i;
    inv = (v >= 0);
    if (v < 0) v = mtree(k, s);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    rd1 = 0; tc1 = 0; ri1 = 0; wi1 = 0; vm1 = '1; tw1 = 0;
    rd2 = 0; tc2 = 0; ri2 = 0; wi2 = 0; vm2 = '1; tw2 = 0;
    rd3 = 0; tc3 = 0; ri3 = 0; wi3 = 0; vm3 = '1; tw3 = 0;
    rd4 = 0; tc4 = 0; ri4 = 0; wi4 = 0; vm4 = '1; tw4 = 0;
  endtask

  task automatic do_reset();
    idle_all();
    rst = 1;
    step();
    rst = 0;
  endtask

  task automatic test_reset();
    idle_all();
    rst = 1;
    rd2 = 1; ri2 = 5; tc2 = 1; wi2 = 5; tw2 = 1;
    step();
    n_run++;
    if ({vic2, inv2, vv2} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_outputs: victim=%0d inv=%0b vld=%0b, want 0/0/0", vic2, inv2, vv2);
    end
    rst = 0; tc2 = 0; rd2 = 1; ri2 = 5;
    step();
    n_run++;
    if (vic2 !== 2'd0 || inv2 !== 1'b0 || vv2 !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_read5: victim=%0d inv=%0b vld=%0b, want 0/0/1", vic2, inv2, vv2);
    end
    rd2 = 0;
    step();
    n_run++;
    if (vv2 !== 1'b0 || vic2 !== 2'd0) begin
      n_fail++;
      $display("FAIL vld_pulse: victim=%0d vld=%0b, want 0/0", vic2, vv2);
    end
  endtask

  task automatic test_set_isolation();
    do_reset();
    tc2 = 1; wi2 = 2; tw2 = 0; step();
    tw2 = 2; step();
    n_run++;
    if (vv2 !== 1'b0) begin
      n_fail++;
      $display("FAIL touch_no_vld: vld=%0b, want 0", vv2);
    end
    tw2 = 1; step();
    tc2 = 0; rd2 = 1; ri2 = 2; step();
    n_run++;
    if (vic2 !== 2'd3 || inv2 !== 1'b0 || vv2 !== 1'b1) begin
      n_fail++;
      $display("FAIL set2_victim: victim=%0d inv=%0b vld=%0b, want 3/0/1", vic2, inv2, vv2);
    end
    ri2 = 3; step();
    n_run++;
    if (vic2 !== 2'd0 || inv2 !== 1'b0) begin
      n_fail++;
      $display("FAIL set3_isolated: victim=%0d inv=%0b, want 0/0", vic2, inv2);
    end
    rd2 = 0;
  endtask

  task automatic test_invalid();
    logic [3:0] masks [3];
    int         want  [3];
    masks = '{4'b1011, 4'b0111, 4'b0000};
    want  = '{2, 3, 0};
    for (int i = 0; i < 3; i++) begin
      rd2 = 1; ri2 = 1; vm2 = masks[i];
      step();
      n_run++;
      if (int'(vic2) != want[i] || inv2 !== 1'b1) begin
        n_fail++;
        $display("FAIL invalid_mask %b: victim=%0d inv=%0b, want %0d/1", masks[i], vic2, inv2, want[i]);
      end
    end
    rd2 = 0; vm2 = 4'b1111;
    step();
    n_run++;
    if (vic2 !== 2'd0 || inv2 !== 1'b1 || vv2 !== 1'b0) begin
      n_fail++;
      $display("FAIL hold: victim=%0d inv=%0b vld=%0b, want 0/1/0", vic2, inv2, vv2);
    end
  endtask

  task automatic test_same_set();
    int want;
    do_reset();
    rd2 = 1; ri2 = 4; tc2 = 1; wi2 = 4; tw2 = 0;
    step();
    want = BYP ? 2 : 0;
    n_run++;
    if (int'(vic2) != want || inv2 !== 1'b0) begin
      n_fail++;
      $display("FAIL same_set: victim=%0d inv=%0b, want %0d/0", vic2, inv2, want);
    end
    tc2 = 0;
    step();
    n_run++;
    if (vic2 !== 2'd2) begin
      n_fail++;
      $display("FAIL same_set_commit: victim=%0d, want 2", vic2);
    end
    // Different sets in one cycle are independent.
    ri2 = 7; tc2 = 1; wi2 = 0; tw2 = 0;
    step();
    n_run++;
    if (vic2 !== 2'd0) begin
      n_fail++;
      $display("FAIL diff_set_read: victim=%0d, want 0", vic2);
    end
    tc2 = 0; ri2 = 0;
    step();
    n_run++;
    if (vic2 !== 2'd2) begin
      n_fail++;
      $display("FAIL diff_set_touch: victim=%0d, want 2", vic2);
    end
    rd2 = 0;
  endtask

  task automatic test_reset_priority();
    do_reset();
    tc2 = 1; wi2 = 6; tw2 = 3; step();
    rst = 1; rd2 = 1; ri2 = 6; tc2 = 1; wi2 = 6; tw2 = 0;
    step();
    n_run++;
    if (vv2 !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_drop_read: vld=%0b, want 0", vv2);
    end
    rst = 0; tc2 = 0; rd2 = 1; ri2 = 6;
    step();
    n_run++;
    if (vic2 !== 2'd0 || vv2 !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_drop_touch: victim=%0d vld=%0b, want 0/1", vic2, vv2);
    end
    // Read the cycle before reset: no pulse once reset is over.
    rd2 = 0; tc2 = 1; wi2 = 6; tw2 = 0; step();
    tc2 = 0; rd2 = 1; ri2 = 6; step();
    rd2 = 0; rst = 1; step();
    rst = 0;
    step();
    n_run++;
    if (vv2 !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_kill_lookup: vld=%0b, want 0", vv2);
    end
    rd2 = 1; ri2 = 6; step();
    n_run++;
    if (vic2 !== 2'd0 || vv2 !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_clears_tree: victim=%0d vld=%0b, want 0/1", vic2, vv2);
    end
    rd2 = 0;
  endtask

  task automatic test_random();
    bit          r_rd [4], r_tc [4];
    int          r_ri [4], r_wi [4], r_tw [4];
    logic [15:0] r_vm [4];
    int          ev [4], gv [4];
    bit          ei [4], evv [4], gi [4], gvv [4];
    bit          done;
    do_reset();
    mreset();
    stamp = 0;
    for (int k = 0; k < 4; k++) begin ev[k] = 0; ei[k] = 0; end
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 4; k++) begin
        r_rd[k] = $urandom_range(0, 1) == 1;
        r_tc[k] = $urandom_range(0, 1) == 1;
        r_ri[k] = $urandom_range(0, 7);
        r_wi[k] = ($urandom_range(0, 1) == 1) ? r_ri[k] : $urandom_range(0, 7);
        r_tw[k] = $urandom_range(0, (2 << k) - 1);
        r_vm[k] = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'hFFFF;
        done = 0;
        if (r_rd[k]) begin
          if (BYP && r_tc[k] && r_wi[k] == r_ri[k]) begin
            mtouch(k, r_wi[k], r_tw[k]);
            done = 1;
          end
          mlook(k, r_ri[k], r_vm[k], ev[k], ei[k]);
        end
        if (r_tc[k] && !done) mtouch(k, r_wi[k], r_tw[k]);
        evv[k] = r_rd[k];
      end
      rd1 = r_rd[0]; tc1 = r_tc[0]; ri1 = 3'(r_ri[0]); wi1 = 3'(r_wi[0]); tw1 = 1'(r_tw[0]); vm1 = r_vm[0][1:0];
      rd2 = r_rd[1]; tc2 = r_tc[1]; ri2 = 3'(r_ri[1]); wi2 = 3'(r_wi[1]); tw2 = 2'(r_tw[1]); vm2 = r_vm[1][3:0];
      rd3 = r_rd[2]; tc3 = r_tc[2]; ri3 = 3'(r_ri[2]); wi3 = 3'(r_wi[2]); tw3 = 3'(r_tw[2]); vm3 = r_vm[2][7:0];
      rd4 = r_rd[3]; tc4 = r_tc[3]; ri4 = 3'(r_ri[3]); wi4 = 3'(r_wi[3]); tw4 = 4'(r_tw[3]); vm4 = r_vm[3];
      step();
      gv[0] = int'(vic1); gi[0] = inv1; gvv[0] = vv1;
      gv[1] = int'(vic2); gi[1] = inv2; gvv[1] = vv2;
      gv[2] = int'(vic3); gi[2] = inv3; gvv[2] = vv3;
      gv[3] = int'(vic4); gi[3] = inv4; gvv[3] = vv4;
      for (int k = 0; k < 4; k++) begin
        n_run++;
        if (gv[k] != ev[k] || gi[k] != ei[k] || gvv[k] != evv[k]) begin
          n_fail++;
          $display("FAIL random wb=%0d cyc=%0d: victim=%0d inv=%0b vld=%0b, want %0d/%0b/%0b",
                   k + 1, c, gv[k], gi[k], gvv[k], ev[k], ei[k], evv[k]);
        end
      end
    end
    idle_all();
  endtask

  initial begin
    rst = 0;
    idle_all();
    test_reset();
    test_set_isolation();
    test_invalid();
    test_same_set();
    test_reset_priority();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
